// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//
// Multi-cycle DATA_WIDTH-bit adder/subtractor. One 4-bit ripple-carry slice
// is reused once per cycle, least-significant nibble first. The carry passes
// from one cycle to the next through a register. This trades latency
// (NUM_NIB cycles) for a much smaller adder.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds its payload stable while
// valid is high and ready is low. in_ready is high only in IDLE. out_valid is
// high only in DONE, and the result stays stable until it is accepted.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE)
//   a, b       operands, DATA_WIDTH bits
//   cin        carry-in for an add; ignored when sub=1
//   sub        1: a-b, 0: a+b+cin
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts the result
//   s          sum/difference (modulo 2^DATA_WIDTH)
//   cout       final carry-out; for a subtract, 1 means no borrow
//   ovf        two's-complement signed overflow
//   busy       high in RUN or DONE
// ---------------------------------------------------------------------------

// 4-bit ripple-carry full-adder chain (the shared slice).
module add4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] sum,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];
endmodule

module nibble_serial_adder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] s,
  output logic                  cout,
  output logic                  ovf,
  output logic                  busy
);
  localparam int NUM_NIB = DATA_WIDTH / 4;
  localparam int CNT_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;

  if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder: DATA_WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Operand shift registers. b_q already holds ~b for a subtract.
  logic [DATA_WIDTH-1:0] a_q, b_q;
  // Result nibbles collected so far. The newest nibble enters at the top.
  logic [DATA_WIDTH-5:0] acc_q;
  logic                  carry_q;
  logic                  a_msb_q, beff_msb_q;
  logic [CNT_W-1:0]      cnt_q;

  // Output registers. They change only on the final RUN edge, so s, cout
  // and ovf keep the last result while the next operation is in flight.
  logic [DATA_WIDTH-1:0] s_q;
  logic                  cout_q, ovf_q;

  logic [3:0]            sum4;
  logic                  co4;
  logic [DATA_WIDTH-1:0] acc_next;
  logic                  accept, last_nib;

  add4_slice u_slice (
    .a   (a_q[3:0]),
    .b   (b_q[3:0]),
    .ci  (carry_q),
    .sum (sum4),
    .co  (co4)
  );

  assign acc_next = {sum4, acc_q};
  assign accept   = in_valid && in_ready;
  assign last_nib = (cnt_q == CNT_W'(NUM_NIB - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_nib) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      a_msb_q    <= 1'b0;
      beff_msb_q <= 1'b0;
      cnt_q      <= '0;
      s_q        <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        a_q        <= a;
        // Subtract as a + ~b + 1: invert b here and force the carry-in.
        b_q        <= sub ? ~b : b;
        carry_q    <= sub ? 1'b1 : cin;
        a_msb_q    <= a[DATA_WIDTH-1];
        beff_msb_q <= sub ? ~b[DATA_WIDTH-1] : b[DATA_WIDTH-1];
        cnt_q      <= '0;
      end
    end else if (state_q == RUN) begin
      acc_q   <= acc_next[DATA_WIDTH-1:4];
      a_q     <= a_q >> 4;
      b_q     <= b_q >> 4;
      carry_q <= co4;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_nib) begin
        s_q    <= acc_next;
        cout_q <= co4;
        // Signed overflow: both addends have the same sign but the sum's
        // sign differs. sum4[3] is the result MSB.
        ovf_q  <= (a_msb_q == beff_msb_q) && (sum4[3] != a_msb_q);
      end
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Directed and random checks of nibble_serial_adder at DATA_WIDTH=16. The
// expected {cout, ovf, s} is pushed to exp_q when an operation is accepted.
// It is popped and compared when the DUT presents out_valid.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout, ovf, busy;

  int tests = 0;
  int fails = 0;
  logic [W+1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  nibble_serial_adder #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W+1:0] pk(input logic c, input logic o, input logic [W-1:0] r);
    return {c, o, r};
  endfunction

  // Reference arithmetic on integers, independent of the slice structure.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
    int sa, sb, ua, ub, r, u;
    logic co, ov;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    ua = int'(ma);
    ub = int'(mb);
    if (ms) begin
      r  = sa - sb;
      u  = ua - ub;
      co = (ua >= ub);
    end else begin
      r  = sa + sb + int'(mc);
      u  = ua + ub + int'(mc);
      co = (u > 65535);
    end
    ov = (r > 32767) || (r < -32768);
    return {co, ov, u[W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic ts, input bit push, input logic [W+1:0] expv);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("start_ready", 32'(in_ready), 32'd1);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (push) exp_q.push_back(expv);
    // The operation in flight must ignore operand changes after acceptance.
    a = W'($urandom); b = W'($urandom);
    cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result();
    int n = 0;
    int bad = 0;
    check("busy_run", 32'(busy), 32'd1);
    while (!out_valid && n < 50) begin
      if (in_ready) bad++;
      tick();
      n++;
    end
    check("latency", 32'(n), 32'd4);
    check("ready_low_run", 32'(bad), 32'd0);
  endtask

  task automatic pop_check();
    logic [W+1:0] e;
    check("out_valid_hi", 32'(out_valid), 32'd1);
    check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("s", 32'(s), 32'(e[W-1:0]));
      check("cout", 32'(cout), 32'(e[W+1]));
      check("ovf", 32'(ovf), 32'(e[W]));
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    tick();
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("ready_back", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic ts, input logic [W+1:0] expv);
    start_op(ta, tb_v, tc, ts, 1'b1, expv);
    wait_result();
    pop_check();
    finish_op();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    logic rc, rs;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    tick();

    // Directed vectors
    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, pk(1'b0, 1'b0, 16'h2233));
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, pk(1'b1, 1'b0, 16'h0000));
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, pk(1'b1, 1'b0, 16'h0000));
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, pk(1'b0, 1'b0, 16'hFFFE));
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, pk(1'b1, 1'b0, 16'h0002));
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, pk(1'b0, 1'b1, 16'h8000));
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, pk(1'b1, 1'b1, 16'h7FFF));

    // Backpressure with input isolation
    out_ready = 1'b0;
    start_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1, pk(1'b0, 1'b0, 16'h2233));
    wait_result();
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = W'($urandom); b = W'($urandom);
      tick();
      check("bp_s", 32'(s), 32'h2233);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    pop_check();
    finish_op();

    // Random operations checked against the integer model
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    // A known nonzero result, so that the reset clearing s is observable
    run_op(16'hA5A5, 16'h1111, 1'b0, 1'b0, pk(1'b0, 1'b0, 16'hB6B6));

    // Reset in the middle of RUN
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, '0);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_s", 32'(s), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    #2 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("no_valid_after_rst", 32'(seen), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, pk(1'b0, 1'b0, 16'h0002));

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle DATA_WIDTH-bit adder/subtractor built around a single instance of the team's existing 4-bit ripple-carry full-adder chain.
- A small FSM feeds the slice one nibble per cycle, least-significant nibble first, and chains the carry between cycles in a register.
- Trades latency for area. Used by the nroot/FP datapath wherever a wide add is needed but a full-width ripple adder is too large.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits. Must be a multiple of 4 and at least 8; other values are an elaboration error.
- NUM_NIB, DATA_WIDTH/4, derived localparam: number of slice passes per operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  DATA_WIDTH  operand A.
- b  input  DATA_WIDTH  operand B.
- cin  input  1  carry-in for an add; ignored when sub=1.
- sub  input  1  1 selects A-B, 0 selects A+B+cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- s  output  DATA_WIDTH  sum/difference.
- cout  output  1  final carry-out. For subtract, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - s=0, cout=0, ovf=0.
  - Nibble counter=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch a_reg=a and b_reg = sub ? ~b : b.
  - Initial carry = sub ? 1 : cin.
  - Also latch sign bits a_msb=a[DW-1] and beff_msb=b_reg[DW-1].
  - Counter=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the slice receives a_reg[3:0], b_reg[3:0] and the carry register.
  - At the edge:
    - Slice sum is shifted into s_reg from the top: s_reg = {sum4, s_reg[DW-1:4]}.
    - a_reg and b_reg shift right by 4.
    - Carry register takes the slice cout.
    - Counter increments.
  - When counter==NUM_NIB-1 at the edge, go to DONE.
  - RUN therefore lasts exactly NUM_NIB cycles.
- DONE:
  - out_valid=1.
  - s, cout and ovf are stable and come directly from registers.
  - cout = carry register.
  - ovf = (a_msb==beff_msb) && (s[DW-1]!=a_msb).
  - On out_valid&&out_ready at an edge: go to IDLE. out_valid is low in the next cycle.
- Outputs after DONE: s, cout and ovf hold their last values after leaving DONE, until the next result overwrites them. They are qualified only by out_valid.
- Latency: operands accepted at edge E0 give out_valid=1 in the cycle after edge E_NUM_NIB, i.e. NUM_NIB cycles after acceptance.
- Throughput: minimum one operation per NUM_NIB+2 cycles. There is no overlap: in_ready is 1 only in IDLE.
- Backpressure: out_ready=0 holds DONE indefinitely. in_valid is ignored while not IDLE, and operand inputs may change freely.
- Operand sampling: operands are sampled only at the accept edge. Later changes on a, b, cin and sub have no effect on the operation in flight.
- Reset mid-operation (RUN or DONE): immediate return to reset values. The partial result is discarded and no out_valid pulse occurs.
- Wrap-around: the result is modulo 2^DATA_WIDTH. Overflow is reported only via cout and ovf; no saturation.

Test Plan (DATA_WIDTH=16, NUM_NIB=4):
- Add: a=0x1234, b=0x0FFF, cin=0, sub=0 -> s=0x2233, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge; in_ready=0 throughout.
- Carry chain through all nibbles: a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0. Separately, a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> s=0xFFFE, cout=0, ovf=0. Separately, a=0x0007, b=0x0005, sub=1 -> s=0x0002, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001 add -> s=0x8000, ovf=1, cout=0. Separately, a=0x8000, b=0x0001 sub -> s=0x7FFF, ovf=1, cout=1.
- Backpressure and input isolation: hold out_ready=0 for 5 cycles in DONE while toggling in_valid, a and b -> s stays 0x2233, in_ready stays 0. One cycle after out_ready=1, out_valid=0 and in_ready=1.
- Reset mid-RUN: assert rst asynchronously (off clock edge) after 2 nibble cycles -> all outputs go to reset values immediately, and no out_valid pulse follows. After rst deasserts, a new add 0x0001+0x0001 gives s=0x0002.
